// File: rtl/handshake_pkg.sv
// Shared definitions for the command-out four-phase handshake block:
// register map, STATUS bit positions and FSM states.
package handshake_pkg;

    localparam logic [1:0] ADDR_CMD     = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam int unsigned STATUS_BUSY     = 0;
    localparam int unsigned STATUS_DONE     = 1;
    localparam int unsigned STATUS_TIMEOUT  = 2;
    localparam int unsigned STATUS_REJECTED = 3;
    localparam int unsigned STATUS_RESP_LSB = 8;

    localparam int unsigned MASK_DONE    = 0;
    localparam int unsigned MASK_TIMEOUT = 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRel,
        StDrain
    } state_e;

endpackage

// File: rtl/handshake_tx_fsm.sv
// Four-phase req/ack sequencer: drives out_cmd/out_req, captures the response
// and runs a saturating per-phase timeout counter.
module handshake_tx_fsm
    import handshake_pkg::*;
#(
    parameter int unsigned CMD_W  = 8,
    parameter int unsigned RESP_W = 8,
    parameter int unsigned TO_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              launch,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [TO_W-1:0]   timeout_limit,
    input  logic              in_ack,
    input  logic [RESP_W-1:0] in_resp,
    output logic [CMD_W-1:0]  out_cmd,
    output logic              out_req,
    output logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done_set,
    output logic              timeout_set
);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d, cnt_sat;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              req_q, req_d;
    logic              expire;

    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // Counts the current cycle, compared against the live limit so edits apply at once.
    assign expire  = (timeout_limit != '0) &&
                     (({1'b0, cnt_q} + (TO_W+1)'(1)) >= {1'b0, timeout_limit});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        resp_d      = resp_q;
        req_d       = req_q;
        done_set    = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (launch) begin
                    cmd_d   = cmd;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (in_ack) begin
                    resp_d  = in_resp;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRel;
                end else if (expire) begin
                    req_d       = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = StDrain;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            StRel: begin
                if (!in_ack) begin
                    done_set = 1'b1;
                    state_d  = StIdle;
                end else if (expire) begin
                    timeout_set = 1'b1;
                    state_d     = StDrain;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            StDrain: begin
                if (!in_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            resp_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            resp_q  <= resp_d;
            req_q   <= req_d;
        end
    end

    assign out_cmd = cmd_q;
    assign out_req = req_q;
    assign resp    = resp_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: rtl/handshake_tx.sv
// Avalon-MM slave that issues software commands to the fabric over a four-phase
// handshake; holds the register file, registered read mux and interrupt.
module handshake_tx
    import handshake_pkg::*;
#(
    parameter int unsigned CMD_W  = 8,
    parameter int unsigned RESP_W = 8,
    parameter int unsigned TO_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [CMD_W-1:0]  out_cmd,
    output logic              out_req,
    input  logic              in_ack,
    input  logic [RESP_W-1:0] in_resp
);

    logic              wr, wr_cmd, wr_status, wr_mask, wr_to;
    logic              launch, busy, done_set, timeout_set;
    logic [RESP_W-1:0] resp;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              rejected_q, rejected_d;
    logic [1:0]        mask_q, mask_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [31:0]       rd_mux, readdata_q;

    assign wr        = chipselect & ~write_n;
    assign wr_cmd    = wr && (address == ADDR_CMD);
    assign wr_status = wr && (address == ADDR_STATUS);
    assign wr_mask   = wr && (address == ADDR_MASK);
    assign wr_to     = wr && (address == ADDR_TIMEOUT);
    assign launch    = wr_cmd && !busy;

    handshake_tx_fsm #(
        .CMD_W  (CMD_W),
        .RESP_W (RESP_W),
        .TO_W   (TO_W)
    ) u_fsm (
        .clk           (clk),
        .reset         (reset),
        .launch        (launch),
        .cmd           (writedata[CMD_W-1:0]),
        .timeout_limit (to_q),
        .in_ack        (in_ack),
        .in_resp       (in_resp),
        .out_cmd       (out_cmd),
        .out_req       (out_req),
        .resp          (resp),
        .busy          (busy),
        .done_set      (done_set),
        .timeout_set   (timeout_set)
    );

    // Hardware set takes priority over a same-cycle write-1-to-clear.
    always_comb begin
        done_d     = done_set | (done_q &
                     ~(wr_status & writedata[STATUS_DONE]));
        timeout_d  = timeout_set | (timeout_q &
                     ~(wr_status & writedata[STATUS_TIMEOUT]));
        rejected_d = (wr_cmd & busy) | (rejected_q &
                     ~(wr_status & writedata[STATUS_REJECTED]));
        mask_d     = wr_mask ? writedata[1:0] : mask_q;
        to_d       = wr_to ? writedata[TO_W-1:0] : to_q;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CMD: rd_mux[CMD_W-1:0] = out_cmd;
            ADDR_STATUS: begin
                rd_mux[STATUS_BUSY]                = busy;
                rd_mux[STATUS_DONE]                = done_q;
                rd_mux[STATUS_TIMEOUT]             = timeout_q;
                rd_mux[STATUS_REJECTED]            = rejected_q;
                rd_mux[STATUS_RESP_LSB +: RESP_W]  = resp;
            end
            ADDR_MASK:    rd_mux[1:0] = mask_q;
            ADDR_TIMEOUT: rd_mux[TO_W-1:0] = to_q;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            rejected_q <= 1'b0;
            mask_q     <= '0;
            to_q       <= '0;
            readdata_q <= '0;
        end else begin
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            rejected_q <= rejected_d;
            mask_q     <= mask_d;
            to_q       <= to_d;
            readdata_q <= rd_mux;
        end
    end

    assign readdata = readdata_q;
    assign irq      = (timeout_q & mask_q[MASK_TIMEOUT]) | (done_q & mask_q[MASK_DONE]);

endmodule
